// File: rtl/dec_vec_issue_q.sv
// Vector issue queue: executes vsetvli in-line (architectural vl/vtype) and buffers the other
// vector ops in a FIFO, stamping each with the vl/vtype live at enqueue.
module dec_vec_issue_q #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned VLEN  = 128
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_vsetvli,
   input  logic [5:0]  in_class,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_rs1_val,
   input  logic        in_rs1_x0,
   input  logic        in_rd_x0,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [5:0]  out_class,
   output logic [31:0] out_rs1_val,
   output logic [10:0] out_vl,
   output logic [5:0]  out_vtype,
   output logic        vl_wb_valid,
   output logic [4:0]  vl_wb_rd,
   output logic [31:0] vl_wb_data,
   output logic [10:0] cfg_vl,
   output logic [5:0]  cfg_vtype
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned EW = 32 + 6 + 32 + 11 + 6;

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW:0]   wptr_q, rptr_q;
   logic          full, empty, accept, set_vl, push, pop;

   logic [10:0]   cfg_vl_q;
   logic [5:0]    cfg_vtype_q;
   logic          wb_valid_q;
   logic [4:0]    wb_rd_q;
   logic [10:0]   wb_vl_q;

   logic [10:0]   zimm;
   logic [2:0]    vsew;
   logic [1:0]    vlmul;
   logic [31:0]   vlmax, cur_vlmax, avl;
   logic          illegal;
   logic [10:0]   vl_new;
   logic [5:0]    vtype_new;

   assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty     = (wptr_q == rptr_q);
   assign in_ready  = !full;
   assign out_valid = !empty;

   assign accept = in_valid & in_ready & ~flush;
   assign set_vl = accept & in_vsetvli;
   assign push   = accept & ~in_vsetvli;
   assign pop    = out_valid & out_ready & ~flush;

   assign {out_instr, out_class, out_rs1_val, out_vl, out_vtype} = mem_q[rptr_q[AW-1:0]];

   assign cfg_vl      = cfg_vl_q;
   assign cfg_vtype   = cfg_vtype_q;
   assign vl_wb_valid = wb_valid_q & ~flush;
   assign vl_wb_rd    = wb_rd_q;
   assign vl_wb_data  = {21'd0, wb_vl_q};

   always_comb begin
      zimm      = in_instr[30:20];
      vsew      = zimm[5:3];
      vlmul     = zimm[1:0];
      vlmax     = (32'(VLEN) >> (32'd3 + 32'(vsew))) << vlmul;
      cur_vlmax = (32'(VLEN) >> (32'd3 + 32'(cfg_vtype_q[4:2]))) << cfg_vtype_q[1:0];
      if (!in_rs1_x0) begin
         avl = in_rs1_val;
      end else if (!in_rd_x0) begin
         avl = vlmax;
      end else begin
         avl = {21'd0, cfg_vl_q};
      end
      // Keep-vl form is only legal when VLMAX is unchanged (and the old vtype was legal).
      illegal = (vsew > 3'd2) | zimm[2] | (zimm[10:6] != 5'd0)
              | (in_rs1_x0 & in_rd_x0 & (cfg_vtype_q[5] | (vlmax != cur_vlmax)));
      vl_new    = illegal ? 11'd0 : 11'((avl < vlmax) ? avl : vlmax);
      vtype_new = illegal ? 6'b100000 : {1'b0, vsew, vlmul};
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         cfg_vl_q    <= '0;
         cfg_vtype_q <= 6'b100000;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_vl_q     <= '0;
      end else begin
         wb_valid_q <= set_vl & ~in_rd_x0;
         if (set_vl) begin
            cfg_vl_q    <= vl_new;
            cfg_vtype_q <= vtype_new;
            wb_rd_q     <= in_instr[11:7];
            wb_vl_q     <= vl_new;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {in_instr, in_class, in_rs1_val, cfg_vl_q, cfg_vtype_q};
            wptr_q <= wptr_q + (AW+1)'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + (AW+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_dec_vec_issue_q.sv
// Directed bench for dec_vec_issue_q: a scoreboard queue of expected entries is filled on
// accepted ops and drained/compared on dequeues; vsetvli results are checked against constants.
module tb_dec_vec_issue_q;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_l = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_vsetvli = 1'b0;
   logic [5:0]  in_class = '0;
   logic [31:0] in_instr = '0;
   logic [31:0] in_rs1_val = '0;
   logic        in_rs1_x0 = 1'b0;
   logic        in_rd_x0 = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [5:0]  out_class;
   logic [31:0] out_rs1_val;
   logic [10:0] out_vl;
   logic [5:0]  out_vtype;
   logic        vl_wb_valid;
   logic [4:0]  vl_wb_rd;
   logic [31:0] vl_wb_data;
   logic [10:0] cfg_vl;
   logic [5:0]  cfg_vtype;

   typedef struct {
      logic [31:0] instr;
      logic [5:0]  cls;
      logic [31:0] rs1;
      logic [10:0] vl;
      logic [5:0]  vtype;
   } entry_t;

   entry_t      sb[$];
   logic [10:0] m_vl = '0;
   logic [5:0]  m_vtype = 6'b100000;
   int          n_pass = 0;
   int          n_total = 0;

   always #5 clk = ~clk;

   dec_vec_issue_q #(.DEPTH(DEPTH), .VLEN(128)) dut (
      .clk(clk), .rst_l(rst_l), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_vsetvli(in_vsetvli), .in_class(in_class),
      .in_instr(in_instr), .in_rs1_val(in_rs1_val), .in_rs1_x0(in_rs1_x0), .in_rd_x0(in_rd_x0),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_class(out_class), .out_rs1_val(out_rs1_val), .out_vl(out_vl),
      .out_vtype(out_vtype), .vl_wb_valid(vl_wb_valid), .vl_wb_rd(vl_wb_rd),
      .vl_wb_data(vl_wb_data), .cfg_vl(cfg_vl), .cfg_vtype(cfg_vtype)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: check handshake against the model, score pops/pushes, then advance.
   task automatic cycle();
      bit     do_pop, do_push;
      entry_t e;
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
      do_pop  = (sb.size() != 0) && out_ready && !flush;
      do_push = in_valid && !in_vsetvli && !flush && (sb.size() < DEPTH);
      if (do_pop) begin
         e = sb.pop_front();
         chk("out_instr", out_instr, e.instr);
         chk("out_class", 32'(out_class), 32'(e.cls));
         chk("out_rs1_val", out_rs1_val, e.rs1);
         chk("out_vl", 32'(out_vl), 32'(e.vl));
         chk("out_vtype", 32'(out_vtype), 32'(e.vtype));
      end
      if (do_push) begin
         e.instr = in_instr;
         e.cls   = in_class;
         e.rs1   = in_rs1_val;
         e.vl    = m_vl;
         e.vtype = m_vtype;
         sb.push_back(e);
      end
      if (flush) sb.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic vset(input logic [31:0] rs1v, input bit rs1x0, input logic [4:0] rd,
                       input logic [10:0] zimm);
      in_valid   = 1'b1;
      in_vsetvli = 1'b1;
      in_class   = 6'b111111;
      in_instr   = {1'b0, zimm, 5'd1, 3'b111, rd, 7'h57};
      in_rs1_val = rs1v;
      in_rs1_x0  = rs1x0;
      in_rd_x0   = (rd == 5'd0);
      cycle();
      in_valid   = 1'b0;
      in_vsetvli = 1'b0;
   endtask

   task automatic op(input logic [5:0] cls, input logic [31:0] instr, input logic [31:0] rs1v);
      in_valid   = 1'b1;
      in_vsetvli = 1'b0;
      in_class   = cls;
      in_instr   = instr;
      in_rs1_val = rs1v;
      in_rs1_x0  = 1'b0;
      in_rd_x0   = 1'b0;
      cycle();
      in_valid = 1'b0;
   endtask

   initial begin
      // Reset release
      #23 rst_l = 1'b1;
      @(posedge clk);
      #1;
      chk("rst cfg_vtype", 32'(cfg_vtype), 32'h20);
      chk("rst cfg_vl", 32'(cfg_vl), 32'd0);
      chk("rst vl_wb_valid", 32'(vl_wb_valid), 32'd0);
      chk("rst out_instr", out_instr, 32'd0);
      cycle();

      // AVL = 100, SEW32 LMUL1 -> vl 4, written back next cycle
      vset(32'd100, 1'b0, 5'd1, 11'h010);
      m_vl = 11'd4; m_vtype = 6'b001000;
      chk("vset1 cfg_vl", 32'(cfg_vl), 32'd4);
      chk("vset1 cfg_vtype", 32'(cfg_vtype), 32'h08);
      chk("vset1 wb_valid", 32'(vl_wb_valid), 32'd1);
      chk("vset1 wb_data", vl_wb_data, 32'd4);
      chk("vset1 wb_rd", 32'(vl_wb_rd), 32'd1);
      cycle();
      chk("vset1 wb pulse", 32'(vl_wb_valid), 32'd0);

      // rs1 = x0, rd = x5, SEW8 LMUL8 -> VLMAX = 128
      vset(32'd0, 1'b1, 5'd5, 11'h003);
      m_vl = 11'd128; m_vtype = 6'b000011;
      chk("vset2 cfg_vl", 32'(cfg_vl), 32'd128);
      chk("vset2 wb_rd", 32'(vl_wb_rd), 32'd5);
      chk("vset2 wb_data", vl_wb_data, 32'd128);

      // Keep-vl form: same VLMAX keeps vl, different VLMAX is illegal
      vset(32'd0, 1'b1, 5'd0, 11'h003);
      chk("keep cfg_vl", 32'(cfg_vl), 32'd128);
      chk("keep wb_valid", 32'(vl_wb_valid), 32'd0);
      vset(32'd0, 1'b1, 5'd0, 11'h002);
      chk("keep chg vtype", 32'(cfg_vtype), 32'h20);
      chk("keep chg vl", 32'(cfg_vl), 32'd0);

      // AVL below VLMAX, then ops stamped across an illegal vsetvli (vsew = 3)
      vset(32'd3, 1'b0, 5'd0, 11'h010);
      m_vl = 11'd3; m_vtype = 6'b001000;
      chk("avl3 cfg_vl", 32'(cfg_vl), 32'd3);
      op(6'b000100, 32'h1234_5057, 32'hdead_beef);
      vset(32'd7, 1'b0, 5'd2, 11'h018);
      m_vl = 11'd0; m_vtype = 6'b100000;
      chk("vill cfg_vtype", 32'(cfg_vtype), 32'h20);
      chk("vill cfg_vl", 32'(cfg_vl), 32'd0);
      op(6'b100000, 32'h0000_1057, 32'h0000_0011);
      out_ready = 1'b1;
      cycle();
      cycle();
      out_ready = 1'b0;
      cycle();

      // Fill to DEPTH, then push+pop at the boundary; order must be preserved
      vset(32'd100, 1'b0, 5'd1, 11'h010);
      m_vl = 11'd4; m_vtype = 6'b001000;
      for (int i = 0; i < DEPTH; i++) op(6'b010000, 32'h100 + i, 32'(i));
      chk("full in_ready", 32'(in_ready), 32'd0);
      in_valid  = 1'b1;
      in_class  = 6'b000001;
      in_instr  = 32'h0000_0555;
      in_rs1_val = 32'h55;
      out_ready = 1'b1;
      cycle();
      cycle();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      out_ready = 1'b0;
      cycle();

      // Flush with 3 queued and a live input
      for (int i = 0; i < 3; i++) op(6'b000010, 32'h200 + i, 32'(i));
      in_valid = 1'b1;
      in_class = 6'b100000;
      in_instr = 32'h0000_0777;
      flush    = 1'b1;
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush out_valid", 32'(out_valid), 32'd0);
      chk("flush cfg_vl", 32'(cfg_vl), 32'd4);
      cycle();

      // Flush in the writeback cycle suppresses vl_wb_valid but not the cfg update
      vset(32'd50, 1'b0, 5'd3, 11'h001);
      m_vl = 11'd32; m_vtype = 6'b000001;
      flush = 1'b1;
      #1;
      chk("wb flush valid", 32'(vl_wb_valid), 32'd0);
      chk("wb flush cfg_vl", 32'(cfg_vl), 32'd32);
      cycle();
      flush = 1'b0;

      // Asynchronous reset mid-operation
      op(6'b001000, 32'h300, 32'h3);
      op(6'b001000, 32'h301, 32'h4);
      #2 rst_l = 1'b0;
      #1;
      chk("arst out_valid", 32'(out_valid), 32'd0);
      chk("arst cfg_vtype", 32'(cfg_vtype), 32'h20);
      chk("arst out_instr", out_instr, 32'd0);
      sb.delete();
      m_vl = '0; m_vtype = 6'b100000;
      #4 rst_l = 1'b1;
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
